pfpu_i2f_rnd: RTL and testbench

//  Parametrised integer-to-single-precision converter for the pfpu32 execute path.

---
 rtl/pfpu_i2f_rnd.sv | 98 +++++++++
 tb/tb_pfpu_i2f_rnd.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pfpu_i2f_rnd.sv
// pfpu_i2f_rnd: 3-stage integer to binary32 converter with IEEE rounding and inexact/zero flags.
// Optional sticky inexact accumulator enabled by defining PFPU_I2F_FLAG_ACC_EN.
module pfpu_i2f_rnd #(
  parameter int INT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 adv_i,
  input  logic                 start_i,
  input  logic                 unsigned_i,
  input  logic [1:0]           rmode_i,
  input  logic [INT_WIDTH-1:0] opa_i,
`ifdef PFPU_I2F_FLAG_ACC_EN
  input  logic                 flag_clr_i,
  output logic                 inexact_acc_o,
`endif
  output logic                 rdy_o,
  output logic [31:0]          result_o,
  output logic                 inexact_o,
  output logic                 zero_o
);
  localparam int W  = INT_WIDTH;
  localparam int LW = $clog2(W);

  if (W != 32 && W != 64) begin : g_bad_width
    $error("pfpu_i2f_rnd: INT_WIDTH must be 32 or 64");
  end

  logic         r_v1, r_v2;
  logic         r_sign1, r_sign2, r_zero1, r_zero2;
  logic [1:0]   r_rm1, r_rm2;
  logic [W-1:0] r_mag1, r_norm2;
  logic [7:0]   r_exp2;

  logic          w_sign, w_g, w_s, w_rnd;
  logic [W-1:0]  w_mag;
  logic [LW-1:0] w_lzc;
  logic [22:0]   w_frac;
  logic [31:0]   w_res;

  assign w_sign = ~unsigned_i & opa_i[W-1];
  assign w_mag  = w_sign ? -opa_i : opa_i;

  // Highest set bit wins; an all-zero magnitude is flagged separately.
  always_comb begin
    w_lzc = LW'(W-1);
    for (int i = 0; i < W; i++)
      if (r_mag1[i]) w_lzc = LW'(W-1-i);
  end

  assign w_frac = r_norm2[W-2:W-24];
  assign w_g    = r_norm2[W-25];
  assign w_s    = |r_norm2[W-26:0];
  assign w_rnd  = (r_rm2 == 2'd0) ? w_g & (w_s | w_frac[0]) :
                  (r_rm2 == 2'd1) ? 1'b0 :
                  (r_rm2 == 2'd2) ? ~r_sign2 & (w_g | w_s) :
                                    r_sign2 & (w_g | w_s);
  // Fraction carry-out ripples into the exponent field naturally.
  assign w_res  = ~r_norm2[W-1] ? 32'h0 : {r_sign2, r_exp2, w_frac} + 32'(w_rnd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1 <= 1'b0; r_v2 <= 1'b0; rdy_o <= 1'b0;
      r_sign1 <= 1'b0; r_zero1 <= 1'b0; r_rm1 <= 2'd0; r_mag1 <= '0;
      r_sign2 <= 1'b0; r_zero2 <= 1'b0; r_rm2 <= 2'd0; r_norm2 <= '0; r_exp2 <= 8'd0;
      result_o <= 32'h0; inexact_o <= 1'b0; zero_o <= 1'b0;
    end else begin
      if (flush_i | adv_i) begin
        r_v1  <= ~flush_i & start_i;
        r_v2  <= ~flush_i & r_v1;
        rdy_o <= ~flush_i & r_v2;
      end
      if (adv_i) begin
        r_sign1   <= w_sign;
        r_zero1   <= w_mag == '0;
        r_rm1     <= rmode_i;
        r_mag1    <= w_mag;
        r_sign2   <= r_sign1;
        r_zero2   <= r_zero1;
        r_rm2     <= r_rm1;
        r_norm2   <= r_mag1 << w_lzc;
        r_exp2    <= 8'(127 + W - 1) - 8'(w_lzc);
        result_o  <= w_res;
        inexact_o <= w_g | w_s;
        zero_o    <= r_zero2;
      end
    end
  end

`ifdef PFPU_I2F_FLAG_ACC_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) inexact_acc_o <= 1'b0;
    else if (rdy_o & adv_i & inexact_o) inexact_acc_o <= 1'b1;
    else if (flag_clr_i) inexact_acc_o <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_pfpu_i2f_rnd.sv
// tb_pfpu_i2f_rnd: table-driven scoreboard bench for pfpu_i2f_rnd (W=32 main, W=64 spot check).
module tb_pfpu_i2f_rnd;
  typedef struct {
    logic        u;
    logic [1:0]  rm;
    logic [31:0] op;
    logic [31:0] res;
    logic        inx;
    logic        zr;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b0;
  logic        flush = 1'b0, adv = 1'b0, start = 1'b0, uns = 1'b0, start64 = 1'b0;
  logic [1:0]  rm = 2'd0;
  logic [31:0] opa = 32'h0;
  logic [63:0] opa64 = 64'h0;
  logic        rdy, inx, zr, rdy64, inx64, zr64;
  logic [31:0] res, res64;
  logic        flag_clr = 1'b0;
  logic        acc, acc64;
  vec_t        tv[17];
  vec_t        q[$];
  vec_t        nv;
  int          checks = 0, errors = 0;
  logic        prev_rdy;
  logic [31:0] prev_res;

  always #5 clk = ~clk;

  pfpu_i2f_rnd #(.INT_WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .flush_i(flush), .adv_i(adv), .start_i(start),
    .unsigned_i(uns), .rmode_i(rm), .opa_i(opa),
`ifdef PFPU_I2F_FLAG_ACC_EN
    .flag_clr_i(flag_clr), .inexact_acc_o(acc),
`endif
    .rdy_o(rdy), .result_o(res), .inexact_o(inx), .zero_o(zr)
  );

  pfpu_i2f_rnd #(.INT_WIDTH(64)) u64 (
    .clk(clk), .rst(rst), .flush_i(flush), .adv_i(adv), .start_i(start64),
    .unsigned_i(uns), .rmode_i(rm), .opa_i(opa64),
`ifdef PFPU_I2F_FLAG_ACC_EN
    .flag_clr_i(flag_clr), .inexact_acc_o(acc64),
`endif
    .rdy_o(rdy64), .result_o(res64), .inexact_o(inx64), .zero_o(zr64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic a, input logic st, input logic fl, input vec_t v);
    adv = a; start = st; flush = fl; uns = v.u; rm = v.rm; opa = v.op;
    if (a && st && !fl) q.push_back(v);
    @(posedge clk); #1;
    if (fl) q.delete();
    else if (a && rdy) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rdy: got result %h with nothing outstanding", res);
      end else begin
        vec_t e = q.pop_front();
        chk("result", res, e.res);
        chk("inexact", inx, e.inx);
        chk("zero", zr, e.zr);
      end
    end else if (!a) begin
      chk("hold_rdy", rdy, prev_rdy);
      chk("hold_result", res, prev_res);
    end
    prev_rdy = rdy; prev_res = res;
    adv = 1'b0; start = 1'b0; flush = 1'b0;
  endtask

  initial begin
    nv = '{u:0, rm:0, op:32'h0, res:32'h0, inx:0, zr:1};
    tv[0]  = '{u:0, rm:0, op:32'h0000_0001, res:32'h3F80_0000, inx:0, zr:0};
    tv[1]  = '{u:0, rm:0, op:32'hFFFF_FFFF, res:32'hBF80_0000, inx:0, zr:0};
    tv[2]  = '{u:0, rm:0, op:32'h7FFF_FFFF, res:32'h4F00_0000, inx:1, zr:0};
    tv[3]  = '{u:0, rm:1, op:32'h7FFF_FFFF, res:32'h4EFF_FFFF, inx:1, zr:0};
    tv[4]  = '{u:0, rm:0, op:32'h8000_0000, res:32'hCF00_0000, inx:0, zr:0};
    tv[5]  = '{u:0, rm:0, op:32'h0100_0001, res:32'h4B80_0000, inx:1, zr:0};
    tv[6]  = '{u:0, rm:2, op:32'h0100_0001, res:32'h4B80_0001, inx:1, zr:0};
    tv[7]  = '{u:1, rm:0, op:32'hFFFF_FFFF, res:32'h4F80_0000, inx:1, zr:0};
    tv[8]  = '{u:0, rm:0, op:32'h0, res:32'h0, inx:0, zr:1};
    tv[9]  = '{u:0, rm:1, op:32'h0, res:32'h0, inx:0, zr:1};
    tv[10] = '{u:0, rm:2, op:32'h0, res:32'h0, inx:0, zr:1};
    tv[11] = '{u:0, rm:3, op:32'h0, res:32'h0, inx:0, zr:1};
    tv[12] = '{u:0, rm:3, op:32'h7FFF_FFFF, res:32'h4EFF_FFFF, inx:1, zr:0};
    tv[13] = '{u:0, rm:3, op:32'h8000_0001, res:32'hCF00_0000, inx:1, zr:0};
    tv[14] = '{u:0, rm:2, op:32'h8000_0001, res:32'hCEFF_FFFF, inx:1, zr:0};
    tv[15] = '{u:0, rm:0, op:32'h0100_0003, res:32'h4B80_0002, inx:1, zr:0};
    tv[16] = '{u:1, rm:0, op:32'h8000_0000, res:32'h4F00_0000, inx:0, zr:0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdy", rdy, 0);
    chk("reset_result", res, 0);
    chk("reset_inexact", inx, 0);
    chk("reset_zero", zr, 0);
    prev_rdy = rdy; prev_res = res;
    rst = 1'b1;

    for (int i = 0; i < 17; i++) step(1, 1, 0, tv[i]);
    repeat (3) step(1, 0, 0, nv);

    for (int i = 0; i < 17; i++) begin
      if (i % 3 != 1) step(0, 0, 0, nv);
      step(1, 1, 0, tv[16-i]);
    end
    for (int i = 0; i < 6; i++) step(i[0], 0, 0, nv);

    step(1, 1, 0, tv[2]);
    chk("lat_adv1", rdy, 0);
    step(0, 0, 0, nv);
    step(1, 0, 0, nv);
    chk("lat_adv2", rdy, 0);
    step(0, 0, 0, nv);
    step(1, 0, 0, nv);
    chk("lat_adv3", rdy, 1);
    step(0, 0, 0, nv);

    step(1, 1, 0, tv[0]);
    step(1, 1, 0, tv[3]);
    step(1, 1, 1, tv[4]);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, nv);
      chk("flush_rdy", rdy, 0);
    end

    opa64 = 64'h8000_0000_0000_0000; start64 = 1'b1;
    step(1, 0, 0, nv);
    start64 = 1'b0;
    step(1, 0, 0, nv);
    step(1, 0, 0, nv);
    chk("w64_rdy", rdy64, 1);
    chk("w64_result", res64, 32'hDF00_0000);
    chk("w64_inexact", inx64, 0);

`ifdef PFPU_I2F_FLAG_ACC_EN
    chk("acc_init", acc, 0);
    step(1, 1, 0, tv[2]);
    step(1, 0, 0, nv);
    step(1, 0, 0, nv);
    flag_clr = 1'b1;
    step(1, 0, 0, nv);
    chk("acc_set_wins", acc, 1);
    step(1, 0, 0, nv);
    flag_clr = 1'b0;
    chk("acc_clear", acc, 0);
`endif

    step(1, 1, 0, tv[2]);
    step(1, 0, 0, nv);
    step(1, 0, 0, nv);
    #2 rst = 1'b0;
    #1;
    chk("rst_rdy", rdy, 0);
    chk("rst_result", res, 0);
    chk("rst_inexact", inx, 0);
    chk("rst_zero", zr, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    prev_rdy = rdy; prev_res = res;

    chk("queue_drained", 64'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
